conv_addr_sequencer: RTL and testbench

- Next-generation address/control sequencer for the 2D convolution datapath.
- Drives the block-memory addresses for three phases: image column load, convolution processing, and result read-out.
- Generalised over address width, pipeline latency, kernel border and number of memory blocks (lanes).
- Uses an explicit encoded state machine and an asynchronous active-low reset.

---
 rtl/conv_ctrl_pkg.sv | 31 +++
 rtl/conv_addr_sequencer_if.sv | 36 +++
 rtl/valid_edge_det.sv | 22 ++
 rtl/conv_addr_sequencer.sv | 166 ++++++++++++++++
 tb/tb_conv_addr_sequencer.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/conv_ctrl_pkg.sv
// Shared definitions for the convolution address sequencer: state encoding,
// default geometry and a constant-safe clog2 for sizing the lane index.
// Latency: n/a (definitions only). Backpressure: n/a.
package conv_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PROC = 2'd2,
        READ = 2'd3
    } state_t;

    localparam int DEF_NB_ADDRESS = 10;
    localparam int DEF_NB_IMAGE   = 10;
    localparam int DEF_N_LANES    = 4;
    localparam int DEF_LATENCY    = 6;
    localparam int DEF_BORDER     = 2;

    // Number of bits needed to index 'value' items (clog2(1) = 0).
    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/conv_addr_sequencer_if.sv
// Host <-> sequencer bundle: phase requests, image height and valid strobe in,
// memory addresses, lane index and phase status out.
// Latency: n/a (wiring only). Backpressure: none; the host paces loads via i_valid.
// master: host/controller side. slave: the sequencer.
interface conv_addr_sequencer_if
    import conv_ctrl_pkg::*;
#(
    parameter int NB_ADDRESS = DEF_NB_ADDRESS,
    parameter int NB_IMAGE   = DEF_NB_IMAGE,
    parameter int NB_LANE    = 2
);
    logic [NB_IMAGE-1:0]   i_imgLength;
    logic                  i_load;
    logic                  i_SoP;
    logic                  i_valid;
    logic [NB_ADDRESS-1:0] o_readAdd;
    logic [NB_ADDRESS-1:0] o_writeAdd;
    logic [NB_LANE-1:0]    o_lane;
    logic                  o_fsm2convVld;
    logic                  o_EoP;
    logic                  o_changeBlock;
    logic                  o_busy;
    logic                  o_err;

    modport master (
        output i_imgLength, i_load, i_SoP, i_valid,
        input  o_readAdd, o_writeAdd, o_lane, o_fsm2convVld,
               o_EoP, o_changeBlock, o_busy, o_err
    );

    modport slave (
        input  i_imgLength, i_load, i_SoP, i_valid,
        output o_readAdd, o_writeAdd, o_lane, o_fsm2convVld,
               o_EoP, o_changeBlock, o_busy, o_err
    );
endinterface

// File: rtl/valid_edge_det.sv
// Rising-edge detector for the host valid strobe.
// Latency: o_rise is combinational from i_valid against the previous-cycle sample.
// Backpressure: none.
// Ports: i_CLK, i_reset (async active-low), i_valid in; o_rise out.
module valid_edge_det (
    input  logic i_CLK,
    input  logic i_reset,
    input  logic i_valid,
    output logic o_rise
);
    logic prevValid;

    always_ff @(posedge i_CLK or negedge i_reset) begin
        if (!i_reset) begin
            prevValid <= 1'b0;
        end else begin
            prevValid <= i_valid;
        end
    end

    assign o_rise = i_valid & ~prevValid;
endmodule

// File: rtl/conv_addr_sequencer.sv
// Address/control sequencer for the 2D convolver: column load, process, read-out.
// Latency: all outputs registered, one cycle after the sampling edge; o_busy decodes state.
// Backpressure: none; load/read-out advance on i_valid rising edges, process free-runs.
// Ports: i_CLK, i_reset (async active-low), seqBus (slave modport) carrying
//        i_imgLength/i_load/i_SoP/i_valid in and addresses, lane and status out.
module conv_addr_sequencer
    import conv_ctrl_pkg::*;
#(
    parameter int NB_ADDRESS = DEF_NB_ADDRESS,
    parameter int NB_IMAGE   = DEF_NB_IMAGE,
    parameter int N_LANES    = DEF_N_LANES,
    parameter int NB_LANE    = clog2(N_LANES),
    parameter int LATENCY    = DEF_LATENCY,
    parameter int BORDER     = DEF_BORDER
) (
    input logic                  i_CLK,
    input logic                  i_reset,
    conv_addr_sequencer_if.slave seqBus
);
    // Common compare width: wide enough for either counter or the height,
    // plus one bit so H-BORDER can never wrap.
    localparam int NB_CMP = ((NB_ADDRESS > NB_IMAGE) ? NB_ADDRESS : NB_IMAGE) + 1;

    state_t                state,       stateNxt;
    logic [NB_ADDRESS-1:0] rdCnt,       rdNxt;
    logic [NB_ADDRESS-1:0] wrCnt,       wrNxt;
    logic [NB_LANE-1:0]    lane,        laneNxt;
    logic [NB_IMAGE-1:0]   height,      heightNxt;
    logic                  eop,         eopNxt;
    logic                  convVld,     convVldNxt;
    logic                  changeBlock, changeBlockNxt;
    logic                  err,         errNxt;

    logic              validRise;
    logic              heightOk;
    logic [NB_CMP-1:0] rdExt, wrExt, hExt, hMinusB;

    valid_edge_det u_validEdge (
        .i_CLK   (i_CLK),
        .i_reset (i_reset),
        .i_valid (seqBus.i_valid),
        .o_rise  (validRise)
    );

    assign rdExt    = NB_CMP'(rdCnt);
    assign wrExt    = NB_CMP'(wrCnt);
    assign hExt     = NB_CMP'(height);
    assign hMinusB  = hExt - NB_CMP'(BORDER);
    // A phase needs at least one row left after the kernel border.
    assign heightOk = NB_CMP'(seqBus.i_imgLength) >= NB_CMP'(BORDER + 1);

    always_ff @(posedge i_CLK or negedge i_reset) begin
        if (!i_reset) begin
            state       <= IDLE;
            rdCnt       <= '0;
            wrCnt       <= '0;
            lane        <= '0;
            height      <= '0;
            eop         <= 1'b0;
            convVld     <= 1'b0;
            changeBlock <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= stateNxt;
            rdCnt       <= rdNxt;
            wrCnt       <= wrNxt;
            lane        <= laneNxt;
            height      <= heightNxt;
            eop         <= eopNxt;
            convVld     <= convVldNxt;
            changeBlock <= changeBlockNxt;
            err         <= errNxt;
        end
    end

    always_comb begin
        stateNxt       = state;
        rdNxt          = rdCnt;
        wrNxt          = wrCnt;
        laneNxt        = lane;
        heightNxt      = height;
        eopNxt         = eop;
        convVldNxt     = convVld;
        changeBlockNxt = 1'b0;
        errNxt         = err;

        case (state)
            IDLE: begin
                rdNxt = '0;
                wrNxt = '0;
                if (seqBus.i_load && seqBus.i_SoP) begin
                    errNxt = 1'b1;
                end else if (seqBus.i_load && !eop) begin
                    if (heightOk) begin
                        stateNxt  = LOAD;
                        heightNxt = seqBus.i_imgLength;
                    end else begin
                        errNxt = 1'b1;
                    end
                end else if (seqBus.i_SoP && !eop) begin
                    if (heightOk) begin
                        stateNxt   = PROC;
                        heightNxt  = seqBus.i_imgLength;
                        convVldNxt = 1'b1;
                    end else begin
                        errNxt = 1'b1;
                    end
                end else if (!seqBus.i_load && !seqBus.i_SoP && eop) begin
                    // Pending results start draining as soon as the host is quiet.
                    if (heightOk) begin
                        stateNxt  = READ;
                        heightNxt = seqBus.i_imgLength;
                    end else begin
                        errNxt = 1'b1;
                    end
                end
            end

            LOAD, READ: begin
                if (rdExt < hExt) begin
                    if (validRise) begin
                        rdNxt = rdCnt + NB_ADDRESS'(1);
                    end
                end else if (!seqBus.i_load) begin
                    // Block is full/drained; hand the next block to the host.
                    stateNxt       = IDLE;
                    rdNxt          = '0;
                    changeBlockNxt = 1'b1;
                    laneNxt        = (lane == NB_LANE'(N_LANES - 1)) ? '0 : lane + NB_LANE'(1);
                    if (state == READ) begin
                        eopNxt = 1'b0;
                    end
                end
            end

            PROC: begin
                if (rdExt != hExt) begin
                    rdNxt = rdCnt + NB_ADDRESS'(1);
                end
                if (wrExt == hMinusB) begin
                    stateNxt   = IDLE;
                    rdNxt      = '0;
                    wrNxt      = '0;
                    convVldNxt = 1'b0;
                    eopNxt     = 1'b1;
                end else if (rdExt >= NB_CMP'(LATENCY) && wrExt < hMinusB) begin
                    // Writes trail reads by the convolver pipeline depth.
                    wrNxt = wrCnt + NB_ADDRESS'(1);
                end
            end

            default: begin
                stateNxt = IDLE;
            end
        endcase
    end

    assign seqBus.o_readAdd     = rdCnt;
    assign seqBus.o_writeAdd    = (state == PROC) ? wrCnt : rdCnt;
    assign seqBus.o_lane        = lane;
    assign seqBus.o_fsm2convVld = convVld;
    assign seqBus.o_EoP         = eop;
    assign seqBus.o_changeBlock = changeBlock;
    assign seqBus.o_busy        = (state != IDLE);
    assign seqBus.o_err         = err;
endmodule

// File: tb/tb_conv_addr_sequencer.sv
// Directed bench for conv_addr_sequencer: load, process, read-out, lane wrap,
// illegal requests and asynchronous reset mid-process.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_conv_addr_sequencer;
    localparam int NB_ADDRESS = 10;
    localparam int NB_IMAGE   = 10;
    localparam int N_LANES    = 4;
    localparam int NB_LANE    = 2;
    localparam int LATENCY    = 6;
    localparam int BORDER     = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    conv_addr_sequencer_if #(
        .NB_ADDRESS (NB_ADDRESS),
        .NB_IMAGE   (NB_IMAGE),
        .NB_LANE    (NB_LANE)
    ) bus ();

    conv_addr_sequencer #(
        .NB_ADDRESS (NB_ADDRESS),
        .NB_IMAGE   (NB_IMAGE),
        .N_LANES    (N_LANES),
        .NB_LANE    (NB_LANE),
        .LATENCY    (LATENCY),
        .BORDER     (BORDER)
    ) dut (
        .i_CLK   (clk),
        .i_reset (rst_n),
        .seqBus  (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.i_imgLength = 10'd10;
        bus.i_load      = 1'b0;
        bus.i_SoP       = 1'b0;
        bus.i_valid     = 1'b0;
        #3 rst_n = 1'b0;
        step();
        checks++; if (bus.o_readAdd !== 10'd0) begin failures++; $display("FAIL reset_readAdd got=%0d exp=0", bus.o_readAdd); end
        checks++; if (bus.o_writeAdd !== 10'd0) begin failures++; $display("FAIL reset_writeAdd got=%0d exp=0", bus.o_writeAdd); end
        checks++; if (bus.o_lane !== 2'd0) begin failures++; $display("FAIL reset_lane got=%0d exp=0", bus.o_lane); end
        checks++; if (bus.o_fsm2convVld !== 1'b0) begin failures++; $display("FAIL reset_vld got=%b exp=0", bus.o_fsm2convVld); end
        checks++; if (bus.o_EoP !== 1'b0) begin failures++; $display("FAIL reset_eop got=%b exp=0", bus.o_EoP); end
        checks++; if (bus.o_changeBlock !== 1'b0) begin failures++; $display("FAIL reset_changeBlock got=%b exp=0", bus.o_changeBlock); end
        checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.o_busy); end
        checks++; if (bus.o_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus.o_err); end
        rst_n = 1'b1;
        step();
        checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", bus.o_busy); end
    endtask

    // One complete load of h rows; one extra valid pulse shows saturation at h.
    task automatic do_load(input int h, input logic [1:0] expLane, input string tag);
        int exp;
        bus.i_imgLength = NB_IMAGE'(h);
        bus.i_load      = 1'b1;
        step();
        checks++; if (bus.o_busy !== 1'b1) begin failures++; $display("FAIL %s_enter_busy got=%b exp=1", tag, bus.o_busy); end
        bus.i_imgLength = '0;  // height must already be latched
        for (int k = 1; k <= h + 1; k++) begin
            bus.i_valid = 1'b1;
            step();
            exp = (k > h) ? h : k;
            checks++; if (bus.o_readAdd !== NB_ADDRESS'(exp)) begin failures++; $display("FAIL %s_readAdd pulse=%0d got=%0d exp=%0d", tag, k, bus.o_readAdd, exp); end
            checks++; if (bus.o_writeAdd !== NB_ADDRESS'(exp)) begin failures++; $display("FAIL %s_writeAdd pulse=%0d got=%0d exp=%0d", tag, k, bus.o_writeAdd, exp); end
            bus.i_valid = 1'b0;
            step();
        end
        step();
        checks++; if (bus.o_changeBlock !== 1'b0 || bus.o_busy !== 1'b1) begin failures++; $display("FAIL %s_hold cb=%b busy=%b exp cb=0 busy=1", tag, bus.o_changeBlock, bus.o_busy); end
        bus.i_load = 1'b0;
        step();
        checks++; if (bus.o_changeBlock !== 1'b1) begin failures++; $display("FAIL %s_changeBlock got=%b exp=1", tag, bus.o_changeBlock); end
        checks++; if (bus.o_lane !== expLane) begin failures++; $display("FAIL %s_lane got=%0d exp=%0d", tag, bus.o_lane, expLane); end
        checks++; if (bus.o_busy !== 1'b0 || bus.o_readAdd !== 10'd0) begin failures++; $display("FAIL %s_exit busy=%b readAdd=%0d exp busy=0 readAdd=0", tag, bus.o_busy, bus.o_readAdd); end
        step();
        checks++; if (bus.o_changeBlock !== 1'b0) begin failures++; $display("FAIL %s_pulse_width got=%b exp=0", tag, bus.o_changeBlock); end
    endtask

    task automatic test_load();
        do_load(10, 2'd1, "load");
    endtask

    task automatic test_proc();
        int vldCount, expRd, expWr;
        logic expEop;
        bus.i_imgLength = 10'd10;
        bus.i_SoP       = 1'b1;
        step();
        bus.i_SoP = 1'b0;
        vldCount = bus.o_fsm2convVld ? 1 : 0;
        checks++; if (bus.o_fsm2convVld !== 1'b1) begin failures++; $display("FAIL proc_vld_start got=%b exp=1", bus.o_fsm2convVld); end
        checks++; if (bus.o_readAdd !== 10'd0 || bus.o_writeAdd !== 10'd0) begin failures++; $display("FAIL proc_start rd=%0d wr=%0d exp 0 0", bus.o_readAdd, bus.o_writeAdd); end
        for (int k = 1; k <= 15; k++) begin
            step();
            if (bus.o_fsm2convVld === 1'b1) vldCount++;
            expRd  = (k >= 15) ? 0 : ((k > 10) ? 10 : k);
            expWr  = (k >= 15) ? 0 : ((k >= 7) ? k - 6 : 0);
            expEop = (k >= 15);
            checks++; if (bus.o_readAdd !== NB_ADDRESS'(expRd)) begin failures++; $display("FAIL proc_readAdd clk=%0d got=%0d exp=%0d", k, bus.o_readAdd, expRd); end
            checks++; if (bus.o_writeAdd !== NB_ADDRESS'(expWr)) begin failures++; $display("FAIL proc_writeAdd clk=%0d got=%0d exp=%0d", k, bus.o_writeAdd, expWr); end
            checks++; if (bus.o_EoP !== expEop) begin failures++; $display("FAIL proc_eop clk=%0d got=%b exp=%b", k, bus.o_EoP, expEop); end
        end
        checks++; if (vldCount != 15) begin failures++; $display("FAIL proc_vld_cycles got=%0d exp=15", vldCount); end
        checks++; if (bus.o_lane !== 2'd1) begin failures++; $display("FAIL proc_lane got=%0d exp=1", bus.o_lane); end
    endtask

    // With EoP pending and no request, the sequencer enters read-out by itself.
    task automatic test_read();
        step();
        checks++; if (bus.o_busy !== 1'b1 || bus.o_EoP !== 1'b1) begin failures++; $display("FAIL read_enter busy=%b eop=%b exp 1 1", bus.o_busy, bus.o_EoP); end
        for (int k = 1; k <= 10; k++) begin
            bus.i_valid = 1'b1;
            step();
            checks++; if (bus.o_readAdd !== NB_ADDRESS'(k) || bus.o_writeAdd !== NB_ADDRESS'(k)) begin failures++; $display("FAIL read_addr pulse=%0d rd=%0d wr=%0d exp=%0d", k, bus.o_readAdd, bus.o_writeAdd, k); end
            bus.i_valid = 1'b0;
            if (k < 10) step();
        end
        step();
        checks++; if (bus.o_changeBlock !== 1'b1) begin failures++; $display("FAIL read_changeBlock got=%b exp=1", bus.o_changeBlock); end
        checks++; if (bus.o_EoP !== 1'b0) begin failures++; $display("FAIL read_eop_clear got=%b exp=0", bus.o_EoP); end
        checks++; if (bus.o_lane !== 2'd2) begin failures++; $display("FAIL read_lane got=%0d exp=2", bus.o_lane); end
        checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL read_exit_busy got=%b exp=0", bus.o_busy); end
        step();
        checks++; if (bus.o_changeBlock !== 1'b0) begin failures++; $display("FAIL read_pulse_width got=%b exp=0", bus.o_changeBlock); end
    endtask

    task automatic test_illegal();
        bus.i_imgLength = 10'd10;
        bus.i_load      = 1'b1;
        bus.i_SoP       = 1'b1;
        step();
        checks++; if (bus.o_err !== 1'b1) begin failures++; $display("FAIL illegal_both_err got=%b exp=1", bus.o_err); end
        checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL illegal_both_busy got=%b exp=0", bus.o_busy); end
        bus.i_load = 1'b0;
        bus.i_SoP  = 1'b0;
        step();
        checks++; if (bus.o_err !== 1'b1 || bus.o_busy !== 1'b0) begin failures++; $display("FAIL illegal_sticky err=%b busy=%b exp 1 0", bus.o_err, bus.o_busy); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        checks++; if (bus.o_err !== 1'b0) begin failures++; $display("FAIL illegal_err_cleared got=%b exp=0", bus.o_err); end
        bus.i_imgLength = 10'd2;
        bus.i_load      = 1'b1;
        step();
        checks++; if (bus.o_err !== 1'b1) begin failures++; $display("FAIL illegal_height_err got=%b exp=1", bus.o_err); end
        checks++; if (bus.o_busy !== 1'b0 || bus.o_readAdd !== 10'd0) begin failures++; $display("FAIL illegal_height_idle busy=%b rd=%0d exp 0 0", bus.o_busy, bus.o_readAdd); end
        bus.i_load = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_proc();
        bus.i_imgLength = 10'd10;
        bus.i_SoP       = 1'b1;
        step();
        bus.i_SoP = 1'b0;
        repeat (5) step();
        checks++; if (bus.o_readAdd !== 10'd5 || bus.o_busy !== 1'b1) begin failures++; $display("FAIL midrst_pre rd=%0d busy=%b exp 5 1", bus.o_readAdd, bus.o_busy); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.o_readAdd !== 10'd0 || bus.o_writeAdd !== 10'd0) begin failures++; $display("FAIL midrst_addr rd=%0d wr=%0d exp 0 0", bus.o_readAdd, bus.o_writeAdd); end
        checks++; if (bus.o_fsm2convVld !== 1'b0 || bus.o_EoP !== 1'b0) begin failures++; $display("FAIL midrst_vld_eop vld=%b eop=%b exp 0 0", bus.o_fsm2convVld, bus.o_EoP); end
        checks++; if (bus.o_busy !== 1'b0 || bus.o_err !== 1'b0 || bus.o_lane !== 2'd0) begin failures++; $display("FAIL midrst_status busy=%b err=%b lane=%0d exp 0 0 0", bus.o_busy, bus.o_err, bus.o_lane); end
        @(posedge clk);
        #1;
        checks++; if (bus.o_changeBlock !== 1'b0) begin failures++; $display("FAIL midrst_changeBlock got=%b exp=0", bus.o_changeBlock); end
        rst_n = 1'b1;
        step();
        bus.i_SoP = 1'b1;
        step();
        bus.i_SoP = 1'b0;
        checks++; if (bus.o_fsm2convVld !== 1'b1 || bus.o_readAdd !== 10'd0) begin failures++; $display("FAIL midrst_restart vld=%b rd=%0d exp 1 0", bus.o_fsm2convVld, bus.o_readAdd); end
        step();
        checks++; if (bus.o_readAdd !== 10'd1) begin failures++; $display("FAIL midrst_restart_count got=%0d exp=1", bus.o_readAdd); end
    endtask

    // Four loads at the minimum legal height walk the lane index 1,2,3,0.
    task automatic test_lane_wrap();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        do_load(3, 2'd1, "wrap1");
        do_load(3, 2'd2, "wrap2");
        do_load(3, 2'd3, "wrap3");
        do_load(3, 2'd0, "wrap4");
        checks++; if (bus.o_err !== 1'b0) begin failures++; $display("FAIL wrap_min_height_err got=%b exp=0", bus.o_err); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_proc();
        test_read();
        test_illegal();
        test_reset_mid_proc();
        test_lane_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
